// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer_pkg
//  Description : Shared types and constants for the fetch-stage PC sequencer:
//                next-PC source encoding, redirect FSM states, PC increment.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

    // Which value the PC register loads at the next rising edge
    typedef enum logic [2:0] {
        SRC_SEQ  = 3'd0,   // sequential fetch, PC+4
        SRC_HOLD = 3'd1,   // stalled, keep current PC
        SRC_BR   = 3'd2,   // EX-stage taken branch
        SRC_JR   = 3'd3,   // ID-stage jr/jalr
        SRC_J    = 3'd4    // ID-stage j/jal
    } pc_src_e;

    // Redirect tracking FSM
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } seq_state_e;

    localparam int PC_INC = 4;

    // True when the selected source changes control flow
    function automatic logic is_redirect(input pc_src_e src);
        return (src == SRC_BR) || (src == SRC_JR) || (src == SRC_J);
    endfunction

endpackage : pc_sequencer_pkg
`default_nettype wire

// File: rtl/pc_target_mux.sv
`default_nettype none
// ============================================================================
//  Module      : pc_target_mux
//  Description : Combinational branch / jump / jump-register target
//                computation and fixed-priority next-PC selection.
//                Priority: branch > jr > j > stall > sequential.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_target_mux
    import pc_sequencer_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_pc_plus4,
    input  logic [N-1:0] branch_offset_sl2,
    input  logic         jump,
    input  logic [25:0]  jump_index,
    input  logic [N-1:0] id_pc_plus4,
    input  logic         jump_reg,
    input  logic [N-1:0] jump_reg_addr,
    input  logic [N-1:0] pc,
    input  logic [N-1:0] pc_plus4,
    output logic [N-1:0] next_pc,
    output pc_src_e      src,
    output logic         jr_misaligned
);

    logic [N-1:0] branch_target;
    logic [N-1:0] jump_target;
    logic [N-1:0] jr_target;

    // Wrap-around add; the carry out of bit N-1 is intentionally dropped
    assign branch_target = branch_pc_plus4 + branch_offset_sl2;

    // jr always fetches a word-aligned address; misalignment is only flagged
    assign jr_target     = {jump_reg_addr[N-1:2], 2'b00};
    assign jr_misaligned = (jump_reg_addr[1:0] != 2'b00);

    // The region bits above the 28-bit jump field exist only when N > 28
    generate
        if (N > 28) begin : g_jump_region
            assign jump_target = {id_pc_plus4[N-1:28], jump_index, 2'b00};
        end else begin : g_jump_flat
            assign jump_target = {jump_index, 2'b00};
        end
    endgenerate

    // Low bits of the ID-stage PC+4 are replaced by the jump index
    logic unused_id_low;
    assign unused_id_low = ^id_pc_plus4[27:0];

    // Priority select: the EX branch is older than any ID-stage jump
    always_comb begin
        src     = SRC_SEQ;
        next_pc = pc_plus4;
        if (branch_taken) begin
            src     = SRC_BR;
            next_pc = branch_target;
        end else if (jump_reg) begin
            src     = SRC_JR;
            next_pc = jr_target;
        end else if (jump) begin
            src     = SRC_J;
            next_pc = jump_target;
        end else if (stall) begin
            src     = SRC_HOLD;
            next_pc = pc;
        end
    end

endmodule : pc_target_mux
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Fetch-stage program counter register with next-PC select,
//                redirect FSM generating one-cycle IF/ID and ID/EX flushes,
//                and a jr alignment fault pulse.
//                Optional feature macro: PC_SEQ_PERF_COUNTERS_EN adds
//                saturating BranchCount / RedirectCount outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = N'(32'h0000_0000)
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Stall,
    input  logic         BranchTaken,
    input  logic [N-1:0] BranchPCPlus4,
    input  logic [N-1:0] BranchOffsetSl2,
    input  logic         Jump,
    input  logic [25:0]  JumpIndex,
    input  logic [N-1:0] IDPCPlus4,
    input  logic         JumpReg,
    input  logic [N-1:0] JumpRegAddr,
    output logic [N-1:0] PC,
    output logic [N-1:0] PCPlus4,
    output logic         FlushIFID,
    output logic         FlushIDEX,
    output logic         AlignFault
`ifdef PC_SEQ_PERF_COUNTERS_EN
   ,output logic [31:0]  BranchCount,
    output logic [31:0]  RedirectCount
`endif
);

    seq_state_e   state;
    seq_state_e   next_state;
    pc_src_e      src;
    logic [N-1:0] next_pc;
    logic         jr_misaligned;
    logic         last_was_branch;

    assign PCPlus4 = PC + N'(PC_INC);

    pc_target_mux #(
        .N (N)
    ) u_target_mux (
        .stall             (Stall),
        .branch_taken      (BranchTaken),
        .branch_pc_plus4   (BranchPCPlus4),
        .branch_offset_sl2 (BranchOffsetSl2),
        .jump              (Jump),
        .jump_index        (JumpIndex),
        .id_pc_plus4       (IDPCPlus4),
        .jump_reg          (JumpReg),
        .jump_reg_addr     (JumpRegAddr),
        .pc                (PC),
        .pc_plus4          (PCPlus4),
        .next_pc           (next_pc),
        .src               (src),
        .jr_misaligned     (jr_misaligned)
    );

    // PC register plus the flush pattern / fault captured with the redirect
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            PC              <= RESET_PC;
            last_was_branch <= 1'b0;
            AlignFault      <= 1'b0;
        end else begin
            PC              <= next_pc;
            last_was_branch <= (src == SRC_BR);
            AlignFault      <= (src == SRC_JR) && jr_misaligned;
        end
    end

    // FSM state register
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state: any selected redirect (re)enters REDIRECT
    always_comb begin
        next_state = RUN;
        if (is_redirect(src)) begin
            next_state = REDIRECT;
        end
    end

    // FSM outputs: branches squash two younger stages, jumps only one
    always_comb begin
        FlushIFID = 1'b0;
        FlushIDEX = 1'b0;
        if (state == REDIRECT) begin
            FlushIFID = 1'b1;
            FlushIDEX = last_was_branch;
        end
    end

`ifdef PC_SEQ_PERF_COUNTERS_EN
    // Saturating event counters, independent of Stall
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            BranchCount   <= 32'd0;
            RedirectCount <= 32'd0;
        end else begin
            if ((src == SRC_BR) && (BranchCount != 32'hFFFF_FFFF)) begin
                BranchCount <= BranchCount + 32'd1;
            end
            if (is_redirect(src) && (RedirectCount != 32'hFFFF_FFFF)) begin
                RedirectCount <= RedirectCount + 32'd1;
            end
        end
    end
`endif

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer. Each cycle the bench
//                predicts the post-edge outputs and queues them; after the
//                edge the DUT outputs are popped and compared.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        Clk = 1'b0;
    logic        Reset_n, Stall, BranchTaken, Jump, JumpReg;
    logic [31:0] BranchPCPlus4, BranchOffsetSl2, IDPCPlus4, JumpRegAddr;
    logic [25:0] JumpIndex;
    logic [31:0] PC, PCPlus4;
    logic        FlushIFID, FlushIDEX, AlignFault;
`ifdef PC_SEQ_PERF_COUNTERS_EN
    logic [31:0] BranchCount, RedirectCount;
`endif

    always #5 Clk = ~Clk;

    pc_sequencer #(
        .N        (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .Stall           (Stall),
        .BranchTaken     (BranchTaken),
        .BranchPCPlus4   (BranchPCPlus4),
        .BranchOffsetSl2 (BranchOffsetSl2),
        .Jump            (Jump),
        .JumpIndex       (JumpIndex),
        .IDPCPlus4       (IDPCPlus4),
        .JumpReg         (JumpReg),
        .JumpRegAddr     (JumpRegAddr),
        .PC              (PC),
        .PCPlus4         (PCPlus4),
        .FlushIFID       (FlushIFID),
        .FlushIDEX       (FlushIDEX),
        .AlignFault      (AlignFault)
`ifdef PC_SEQ_PERF_COUNTERS_EN
       ,.BranchCount     (BranchCount),
        .RedirectCount   (RedirectCount)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic        fi;
        logic        fe;
        logic        af;
        logic [31:0] bc;
        logic [31:0] rc;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state (what the DUT should show after the next edge)
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_bc = 32'h0;
    logic [31:0] m_rc = 32'h0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        Reset_n         = 1'b1;
        Stall           = 1'b0;
        BranchTaken     = 1'b0;
        BranchPCPlus4   = 32'h0;
        BranchOffsetSl2 = 32'h0;
        Jump            = 1'b0;
        JumpIndex       = 26'h0;
        IDPCPlus4       = 32'h0;
        JumpReg         = 1'b0;
        JumpRegAddr     = 32'h0;
    endtask

    // Predict from the currently driven inputs, clock once, compare, and
    // return at the falling edge so the caller can drive the next cycle.
    task automatic tick(input string tag);
        exp_t e;
        exp_t o;
        e.fi = 1'b0; e.fe = 1'b0; e.af = 1'b0;
        if (!Reset_n) begin
            m_pc = RESET_PC; m_bc = 32'h0; m_rc = 32'h0;
        end else if (BranchTaken) begin
            m_pc = BranchPCPlus4 + BranchOffsetSl2;
            e.fi = 1'b1; e.fe = 1'b1;
            if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
            if (m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 1;
        end else if (JumpReg) begin
            m_pc = JumpRegAddr & 32'hFFFF_FFFC;
            e.fi = 1'b1;
            e.af = (JumpRegAddr[1:0] != 2'b00);
            if (m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 1;
        end else if (Jump) begin
            m_pc = {IDPCPlus4[31:28], JumpIndex, 2'b00};
            e.fi = 1'b1;
            if (m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 1;
        end else if (!Stall) begin
            m_pc = m_pc + 32'd4;
        end
        e.pc = m_pc; e.bc = m_bc; e.rc = m_rc;
        sb_q.push_back(e);

        @(posedge Clk);
        #1;
        o = sb_q.pop_front();
        check({tag, ".pc"},      {32'h0, PC},         {32'h0, o.pc});
        check({tag, ".pcplus4"}, {32'h0, PCPlus4},    {32'h0, o.pc + 32'd4});
        check({tag, ".flushif"}, {63'h0, FlushIFID},  {63'h0, o.fi});
        check({tag, ".flushex"}, {63'h0, FlushIDEX},  {63'h0, o.fe});
        check({tag, ".align"},   {63'h0, AlignFault}, {63'h0, o.af});
`ifdef PC_SEQ_PERF_COUNTERS_EN
        check({tag, ".brcnt"},   {32'h0, BranchCount},   {32'h0, o.bc});
        check({tag, ".rdcnt"},   {32'h0, RedirectCount}, {32'h0, o.rc});
`endif
        @(negedge Clk);
    endtask

    initial begin
        idle_inputs();
        Reset_n = 1'b0;
        tick("rst0");
        tick("rst1");
        Reset_n = 1'b1;
        tick("run4");
        tick("run8");
        tick("runC");

        // Sequential fetch up to 0x40, bounded
        for (int i = 0; i < 20 && m_pc != 32'h40; i++) tick("seq");
        check("reach40", {32'h0, m_pc}, 64'h40);

        // Three stalled cycles, then resume
        Stall = 1'b1;
        repeat (3) tick("stall");
        Stall = 1'b0;
        tick("resume");

        // Branch with negative offset
        BranchTaken = 1'b1; BranchPCPlus4 = 32'h100; BranchOffsetSl2 = 32'hFFFF_FFF0;
        tick("branch");
        idle_inputs();
        tick("post_br");

        // Jump into region of ID PC+4
        Jump = 1'b1; IDPCPlus4 = 32'h1000_0008; JumpIndex = 26'h0000040;
        tick("jump");
        idle_inputs();
        tick("post_j");

        // Misaligned jr overrides stall
        JumpReg = 1'b1; JumpRegAddr = 32'h203; Stall = 1'b1;
        tick("jr");
        idle_inputs();
        tick("post_jr");

        // Back-to-back redirects: branch then jump re-pulses with jump pattern
        BranchTaken = 1'b1; BranchPCPlus4 = 32'h500; BranchOffsetSl2 = 32'h40;
        tick("b2b_br");
        idle_inputs();
        Jump = 1'b1; IDPCPlus4 = 32'h2000_0000; JumpIndex = 26'h0000123;
        tick("b2b_j");
        idle_inputs();
        tick("b2b_idle");

        // Carry out of the branch add is discarded
        BranchTaken = 1'b1; BranchPCPlus4 = 32'hFFFF_FFF0; BranchOffsetSl2 = 32'h20;
        tick("br_wrap");
        idle_inputs();

        // Branch and jump together, then reset during the REDIRECT cycle
        BranchTaken = 1'b1; BranchPCPlus4 = 32'h300; BranchOffsetSl2 = 32'h20;
        Jump = 1'b1; IDPCPlus4 = 32'h3000_0000; JumpIndex = 26'h0000777;
        tick("br_and_j");
        Reset_n = 1'b0;
        tick("rst_mid");
        idle_inputs();
        tick("after_rst");

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            Reset_n         = ($urandom_range(0, 24) != 0);
            Stall           = ($urandom_range(0, 3) == 0);
            BranchTaken     = ($urandom_range(0, 4) == 0);
            Jump            = ($urandom_range(0, 4) == 0);
            JumpReg         = ($urandom_range(0, 5) == 0);
            BranchPCPlus4   = $urandom;
            BranchOffsetSl2 = $urandom;
            IDPCPlus4       = $urandom;
            JumpIndex       = 26'($urandom);
            JumpRegAddr     = $urandom;
            tick("rand");
        end
        idle_inputs();
        tick("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-stage program counter register and next-PC selector for the pipelined MIPS core.
- Directly downstream of the branch-offset shift-left-by-2 stage: consumes its output (sign-extended immediate << 2) and adds it to the branch instruction's PC+4 to form the branch target.
- Also selects jump and jump-register targets, applies stalls, and generates registered one-cycle flush pulses for the IF/ID and ID/EX pipeline registers.

Parameters:
- N, 32, datapath / PC width in bits (>= 28).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- Stall  in  1  hazard-unit stall request; hold PC.
- BranchTaken  in  1  EX-stage branch resolved taken.
- BranchPCPlus4  in  N  PC+4 of the branch instruction (from ID/EX).
- BranchOffsetSl2  in  N  shifted branch offset from the shift-left-2 stage.
- Jump  in  1  ID-stage j/jal decoded.
- JumpIndex  in  26  instr[25:0] of the jump.
- IDPCPlus4  in  N  PC+4 of the ID-stage instruction.
- JumpReg  in  1  ID-stage jr/jalr decoded.
- JumpRegAddr  in  N  rs value for jr.
- PC  out  N  current fetch address (registered).
- PCPlus4  out  N  PC+4, combinational, modulo 2^N.
- FlushIFID  out  1  registered one-cycle flush of IF/ID.
- FlushIDEX  out  1  registered one-cycle flush of ID/EX.
- AlignFault  out  1  registered one-cycle pulse on misaligned jr target.

Behaviour:
- Reset: at a rising edge with Reset_n=0:
  - PC=RESET_PC.
  - FlushIFID=FlushIDEX=AlignFault=0.
  - state=RUN.
  - Reset overrides all other inputs, including mid-redirect.
- Arithmetic: all adds are N-bit unsigned with wrap-around; carry is discarded.
  - Branch target = BranchPCPlus4 + BranchOffsetSl2.
  - Jump target = {IDPCPlus4[N-1:28], JumpIndex, 2'b00}.
  - JR target = {JumpRegAddr[N-1:2], 2'b00}.
- Next-PC priority: BranchTaken > JumpReg > Jump > Stall > PC+4.
  - Redirects override Stall; the EX branch is older than the ID jump.
- Flush rules:
  - Branch redirect: next cycle FlushIFID=1 and FlushIDEX=1.
  - Jump/JR redirect: next cycle FlushIFID=1 only.
- AlignFault: next cycle =1 iff JumpReg is the selected source and JumpRegAddr[1:0]!=0.
  - The PC still loads the cleared-low-bits target.
- FSM states:
  - RUN: no redirect was taken last cycle; flush outputs are 0.
  - REDIRECT: a redirect was taken last cycle; flush outputs are asserted per the flush rules.
  - RUN -> REDIRECT on any selected redirect. REDIRECT -> RUN if no new redirect.
  - REDIRECT -> REDIRECT on a new redirect: flushes re-pulse with the new source's pattern.
- Latency: a redirect presented in cycle t makes PC = target at edge t+1.
- Stall with no redirect: PC holds; flush outputs are 0 (after any pending REDIRECT cycle completes).
- Simultaneous BranchTaken and Jump: the branch wins; the jump instruction is flushed.

Optional Feature:
- Macro: PC_SEQ_PERF_COUNTERS_EN.
- When defined:
  - Adds outputs BranchCount[31:0] and RedirectCount[31:0].
  - BranchCount increments on each taken branch; RedirectCount on every selected redirect.
  - Both reset to 0, saturate at 32'hFFFF_FFFF, and are unaffected by Stall.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: the next-PC source enum (SRC_SEQ, SRC_HOLD, SRC_BR, SRC_JR, SRC_J), the FSM state encoding (RUN, REDIRECT), and constant PC_INC=4.
- One sub-module: pc_target_mux, combinational target computation and priority select.
- The register, FSM and counters stay in pc_sequencer.

Test Plan:
- Reset_n=0 for 2 cycles, then 1, no inputs -> PC 0,0,4,8,C; all flush outputs 0.
- PC=0x40, Stall=1 for 3 cycles -> PC stays 0x40; next cycle without stall -> 0x44.
- BranchTaken=1, BranchPCPlus4=0x100, BranchOffsetSl2=0xFFFFFFF0 -> PC=0xF0 next edge; FlushIFID=FlushIDEX=1 for exactly one cycle.
- Jump=1, IDPCPlus4=0x1000_0008, JumpIndex=0x0000040 -> PC=0x1000_0100; FlushIFID=1, FlushIDEX=0.
- JumpReg=1, JumpRegAddr=0x203 with Stall=1 -> PC=0x200; AlignFault=1 for one cycle.
- BranchTaken and Jump asserted together, then Reset_n=0 in the REDIRECT cycle -> branch target taken first; then PC=RESET_PC with all flushes 0.
